// File: rtl/cache_fill_controller_pkg.sv
// Shared definitions for the pixel-cache fill controller: state encoding and
// the default-derived index/tag widths used by the cache datapath.
package cache_fill_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_UPDATE,
    ST_FLUSH
  } state_t;

  localparam int unsigned DEF_ADDRESS_WIDTH     = 10;
  localparam int unsigned DEF_MEM_ADDRESS_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH        = 8;
  localparam int unsigned DEF_LINE_WORDS_LOG2   = 2;

  localparam int unsigned INDEX_WIDTH = DEF_ADDRESS_WIDTH - DEF_LINE_WORDS_LOG2;
  localparam int unsigned TAG_WIDTH   = DEF_MEM_ADDRESS_WIDTH - DEF_ADDRESS_WIDTH;

  function automatic int unsigned index_width(int unsigned aw, int unsigned lw_log2);
    return aw - lw_log2;
  endfunction

  function automatic int unsigned tag_width(int unsigned maw, int unsigned aw);
    return maw - aw;
  endfunction

endpackage

// File: rtl/cache_fill_controller_tag_store.sv
// Tag array plus valid vector for the direct-mapped pixel cache: combinational
// lookup compare, one tag write port and a per-index valid clear.
module cache_tag_store
  import cache_fill_controller_pkg::*;
#(
  parameter int unsigned IDX_W = INDEX_WIDTH,
  parameter int unsigned TAG_W = TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_lookup_index,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_match,
  input  logic             i_write,
  input  logic [IDX_W-1:0] i_write_index,
  input  logic [TAG_W-1:0] i_write_tag,
  input  logic             i_clear,
  input  logic [IDX_W-1:0] i_clear_index
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  logic [TAG_W-1:0]   r_tags [ENTRIES];
  logic [ENTRIES-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clear) r_valid[i_clear_index] <= 1'b0;
      if (i_write) r_valid[i_write_index] <= 1'b1;
    end
  end

  // Tags need no reset: a tag is only ever compared behind its valid bit.
  always_ff @(posedge clk) begin
    if (i_write) r_tags[i_write_index] <= i_write_tag;
  end

  assign o_match = r_valid[i_lookup_index] && (r_tags[i_lookup_index] == i_lookup_tag);

endmodule

// File: rtl/cache_fill_controller.sv
// Miss/fill/flush sequencer for the downsample block's read-only pixel cache.
// Holds the processor on a miss, fetches one line from DDR and writes it in.
module cache_fill_controller
  import cache_fill_controller_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
  parameter int unsigned MEM_ADDRESS_WIDTH = DEF_MEM_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int unsigned LINE_WORDS_LOG2   = DEF_LINE_WORDS_LOG2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ProcRead,
  input  logic [MEM_ADDRESS_WIDTH-1:0] ProcAddress,
  output logic                         ProcStall,
  input  logic                         Flush,
  output logic                         FlushBusy,
  output logic                         Select,
  output logic [ADDRESS_WIDTH-1:0]     FSMAddress,
  output logic                         CacheWrite,
  output logic [DATA_WIDTH-1:0]        CacheWriteData,
  output logic                         MemReadReq,
  output logic [MEM_ADDRESS_WIDTH-1:0] MemAddress,
  input  logic                         MemReadAck,
  input  logic [DATA_WIDTH-1:0]        MemReadData,
  input  logic                         MemDataValid
);

  localparam int unsigned IDX_W = index_width(ADDRESS_WIDTH, LINE_WORDS_LOG2);
  localparam int unsigned TAG_W = tag_width(MEM_ADDRESS_WIDTH, ADDRESS_WIDTH);

  state_t                   r_state, w_next_state;
  logic [TAG_W-1:0]         r_tag;
  logic [IDX_W-1:0]         r_index;
  logic [LINE_WORDS_LOG2-1:0] r_word_cnt;
  logic [LINE_WORDS_LOG2:0] r_beat_cnt;
  logic [IDX_W-1:0]         r_flush_cnt;
  logic                     r_flush_pend;
  logic                     r_cache_write;
  logic [DATA_WIDTH-1:0]    r_wdata;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_index;
  logic             w_match;
  logic             w_miss;
  logic             w_flush_req;
  logic             w_beat_accept;
  logic             w_tag_write;
  logic             w_clear;
  logic             w_unused_word;

  assign w_tag         = ProcAddress[MEM_ADDRESS_WIDTH-1:ADDRESS_WIDTH];
  assign w_index       = ProcAddress[ADDRESS_WIDTH-1:LINE_WORDS_LOG2];
  assign w_unused_word = ^ProcAddress[LINE_WORDS_LOG2-1:0];
  assign w_miss        = ProcRead & ~w_match;
  assign w_flush_req   = Flush | r_flush_pend;
  // Beat counter MSB set means the whole line has arrived; later beats are dropped.
  assign w_beat_accept = (r_state == ST_DATA) & MemDataValid & ~r_beat_cnt[LINE_WORDS_LOG2];

  cache_tag_store #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tag_store (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_lookup_index (w_index),
    .i_lookup_tag   (w_tag),
    .o_match        (w_match),
    .i_write        (w_tag_write),
    .i_write_index  (r_index),
    .i_write_tag    (r_tag),
    .i_clear        (w_clear),
    .i_clear_index  (r_flush_cnt)
  );

  always_comb begin
    w_next_state = r_state;
    w_tag_write  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_flush_req)  w_next_state = ST_FLUSH;
        else if (w_miss)  w_next_state = ST_REQ;
      end
      ST_REQ: begin
        if (MemReadAck) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (r_cache_write && (&r_word_cnt)) w_next_state = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_tag_write  = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_FLUSH: begin
        w_clear = 1'b1;
        if (&r_flush_cnt) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tag         <= '0;
      r_index       <= '0;
      r_word_cnt    <= '0;
      r_beat_cnt    <= '0;
      r_flush_cnt   <= '0;
      r_flush_pend  <= 1'b0;
      r_cache_write <= 1'b0;
      r_wdata       <= '0;
    end else begin
      r_state       <= w_next_state;
      r_cache_write <= w_beat_accept;
      if (w_beat_accept) r_wdata <= MemReadData;

      if ((r_state == ST_IDLE) && !w_flush_req && w_miss) begin
        r_tag   <= w_tag;
        r_index <= w_index;
      end

      // A flush seen mid-fill waits for the line to land, then wipes it too.
      if (r_state inside {ST_REQ, ST_DATA, ST_UPDATE}) begin
        if (Flush) r_flush_pend <= 1'b1;
      end else if (r_state == ST_IDLE) begin
        r_flush_pend <= 1'b0;
      end

      if (r_state == ST_DATA) begin
        if (w_beat_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
        if (r_cache_write) r_word_cnt <= r_word_cnt + 1'b1;
      end else begin
        r_beat_cnt <= '0;
        r_word_cnt <= '0;
      end

      if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
      else                     r_flush_cnt <= '0;
    end
  end

  assign ProcStall      = (r_state != ST_IDLE) | w_miss | Flush;
  assign FlushBusy      = (r_state == ST_FLUSH) | r_flush_pend;
  assign Select         = r_state inside {ST_REQ, ST_DATA, ST_UPDATE};
  assign MemReadReq     = (r_state == ST_REQ);
  assign MemAddress     = {r_tag, r_index, {LINE_WORDS_LOG2{1'b0}}};
  assign FSMAddress     = {r_index, r_word_cnt};
  assign CacheWrite     = r_cache_write;
  assign CacheWriteData = r_wdata;

endmodule

// File: tb/tb_cache_fill_controller.sv
// Randomized self-checking bench for cache_fill_controller against a
// tag/valid array model of the cache and a queue of expected line writes.
module tb_cache_fill_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ProcRead = 1'b0;
  logic [15:0] ProcAddress = '0;
  logic        ProcStall;
  logic        Flush = 1'b0;
  logic        FlushBusy;
  logic        Select;
  logic [9:0]  FSMAddress;
  logic        CacheWrite;
  logic [7:0]  CacheWriteData;
  logic        MemReadReq;
  logic [15:0] MemAddress;
  logic        MemReadAck = 1'b0;
  logic [7:0]  MemReadData = '0;
  logic        MemDataValid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  bit       valid_m [256];
  bit [5:0] tag_m   [256];

  logic [17:0] exp_wr [$];
  logic [17:0] got_wr [$];

  cache_fill_controller #(
    .ADDRESS_WIDTH     (10),
    .MEM_ADDRESS_WIDTH (16),
    .DATA_WIDTH        (8),
    .LINE_WORDS_LOG2   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ProcRead       (ProcRead),
    .ProcAddress    (ProcAddress),
    .ProcStall      (ProcStall),
    .Flush          (Flush),
    .FlushBusy      (FlushBusy),
    .Select         (Select),
    .FSMAddress     (FSMAddress),
    .CacheWrite     (CacheWrite),
    .CacheWriteData (CacheWriteData),
    .MemReadReq     (MemReadReq),
    .MemAddress     (MemAddress),
    .MemReadAck     (MemReadAck),
    .MemReadData    (MemReadData),
    .MemDataValid   (MemDataValid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (CacheWrite === 1'b1) got_wr.push_back({FSMAddress, CacheWriteData});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 256; i++) valid_m[i] = 1'b0;
  endtask

  task automatic compare_writes();
    check("wr_count", got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check("wr_addr_data", got_wr[i], exp_wr[i]);
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic count_flush_busy(input int pulse_at, output int cnt);
    cnt = 0;
    #1;
    while (FlushBusy === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clk);
      Flush = (cnt == pulse_at);
      #1;
    end
    Flush = 1'b0;
  endtask

  // Called right after a negedge; returns right after a negedge with ProcRead low.
  task automatic do_read(input logic [15:0] addr, input int ack_dly, input int max_gap,
                         input bit flush_mid, input int data_base);
    int unsigned idx;
    bit [5:0]    tag;
    bit          exp_hit;
    int          n, gsum, g, bound, cnt;
    logic [7:0]  d;
    idx     = addr[9:2];
    tag     = addr[15:10];
    exp_hit = valid_m[idx] && (tag_m[idx] == tag);
    got_wr.delete();
    exp_wr.delete();
    ProcRead    = 1'b1;
    ProcAddress = addr;
    #1;
    check("stall_on_request", ProcStall, !exp_hit);
    if (exp_hit) begin
      @(negedge clk);
      ProcRead = 1'b0;
      #1;
      check("hit_no_memreq", MemReadReq, 0);
      check("hit_no_write", got_wr.size(), 0);
      got_wr.delete();
      return;
    end
    n    = 1;
    gsum = 0;
    @(negedge clk);
    for (int k = 0; k < ack_dly; k++) begin
      MemDataValid = $urandom_range(0, 1);
      MemReadData  = 8'($urandom);
      #1;
      check("memreq_held", MemReadReq, 1);
      check("mem_line_addr", MemAddress, addr & 16'hFFFC);
      check("select_req", Select, 1);
      @(negedge clk);
      n++;
    end
    MemDataValid = 1'b0;
    MemReadAck   = 1'b1;
    #1;
    check("memreq_at_ack", MemReadReq, 1);
    check("mem_line_addr", MemAddress, addr & 16'hFFFC);
    @(negedge clk);
    n++;
    MemReadAck = 1'b0;
    for (int b = 0; b < 4; b++) begin
      g = $urandom_range(0, max_gap);
      gsum += g;
      repeat (g) begin
        MemReadData = 8'($urandom);
        #1;
        check("select_data_gap", Select, 1);
        check("stall_data_gap", ProcStall, 1);
        @(negedge clk);
        n++;
      end
      d = (data_base >= 0) ? 8'(data_base + b) : 8'($urandom);
      MemDataValid = 1'b1;
      MemReadData  = d;
      exp_wr.push_back({idx[7:0], 2'(b), d});
      if (flush_mid && b == 1) Flush = 1'b1;
      #1;
      check("select_beat", Select, 1);
      @(negedge clk);
      n++;
      MemDataValid = 1'b0;
      Flush        = 1'b0;
    end
    bound = 0;
    #1;
    while (ProcStall !== 1'b0 && bound < 20) begin
      @(negedge clk);
      n++;
      bound++;
      #1;
    end
    check("stall_released", ProcStall, 0);
    check("miss_penalty", n, 8 + ack_dly + gsum);
    check("idle_select", Select, 0);
    compare_writes();
    valid_m[idx] = 1'b1;
    tag_m[idx]   = tag;
    if (flush_mid) begin
      check("flush_pending_busy", FlushBusy, 1);
      @(negedge clk);
      ProcRead = 1'b0;
      count_flush_busy(-1, cnt);
      check("flush_after_fill_len", cnt, 256);
      model_flush();
    end else begin
      @(negedge clk);
      ProcRead = 1'b0;
    end
  endtask

  task automatic flush_idle();
    int cnt;
    Flush = 1'b1;
    #1;
    check("flush_pulse_stall", ProcStall, 1);
    check("flush_pulse_busy", FlushBusy, 0);
    @(negedge clk);
    Flush = 1'b0;
    count_flush_busy(100, cnt);
    check("flush_idle_len", cnt, 256);
    model_flush();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"},  ProcStall, 0);
    check({tag, "_fbusy"},  FlushBusy, 0);
    check({tag, "_select"}, Select, 0);
    check({tag, "_fsmaddr"}, FSMAddress, 0);
    check({tag, "_cwrite"}, CacheWrite, 0);
    check({tag, "_cwdata"}, CacheWriteData, 0);
    check({tag, "_memreq"}, MemReadReq, 0);
    check({tag, "_memaddr"}, MemAddress, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    logic [5:0]  rt;
    logic [7:0]  ri;
    logic [7:0]  idx_pool [4];
    idx_pool[0] = 8'h8D;
    idx_pool[1] = 8'h8E;
    idx_pool[2] = 8'h00;
    idx_pool[3] = 8'hFF;
    model_flush();

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_read(16'h1234, 0, 0, 1'b0, 8'hA0);
    do_read(16'h1234, 0, 0, 1'b0, -1);
    do_read(16'h1235, 0, 0, 1'b0, -1);
    do_read(16'h5234, 1, 0, 1'b0, -1);
    do_read(16'h1234, 5, 3, 1'b0, -1);
    do_read(16'h1236, 0, 0, 1'b0, -1);
    do_read(16'h1238, 2, 2, 1'b1, -1);
    do_read(16'h1234, 0, 1, 1'b0, -1);

    // Reset in the middle of a line fill.
    got_wr.delete();
    ProcRead    = 1'b1;
    ProcAddress = 16'h3234;
    #1;
    check("rst_fill_miss", ProcStall, 1);
    @(negedge clk);
    MemReadAck = 1'b1;
    @(negedge clk);
    MemReadAck   = 1'b0;
    MemDataValid = 1'b1;
    MemReadData  = 8'h11;
    @(negedge clk);
    MemReadData  = 8'h22;
    @(negedge clk);
    rst_n        = 1'b0;
    ProcRead     = 1'b0;
    MemDataValid = 1'b1;
    MemReadData  = 8'h33;
    @(negedge clk);
    #1;
    check_reset_outputs("midfill_reset");
    rst_n = 1'b1;
    @(negedge clk);
    MemDataValid = 1'b0;
    #1;
    check("late_beat_no_write", CacheWrite, 0);
    check("late_beat_no_req", MemReadReq, 0);
    check("pre_reset_writes", got_wr.size(), 2);
    got_wr.delete();
    model_flush();
    @(negedge clk);
    do_read(16'h1234, 0, 0, 1'b0, -1);

    flush_idle();
    do_read(16'h1234, 0, 0, 1'b0, -1);

    for (int t = 0; t < 60; t++) begin
      rt = 6'($urandom_range(0, 3));
      ri = idx_pool[$urandom_range(0, 3)];
      a  = {rt, ri, 2'($urandom)};
      do_read(a, $urandom_range(0, 6), 3, ($urandom_range(0, 9) == 0), -1);
      if ($urandom_range(0, 14) == 0) flush_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_controller.md
# cache_fill_controller

Sequencing controller for the downsample block's direct-mapped, read-only pixel cache. It owns the cache address mux select and tag/valid state. It holds the processor on a miss, fetches a full line from DDR over a request/acknowledge plus data-valid interface, and writes each word into the cache RAM. It also provides a sequenced invalidate (flush).

## Interface
Parameters:
- ADDRESS_WIDTH, 10, cache RAM word-address width (matches the cache address mux)
- MEM_ADDRESS_WIDTH, 16, processor/DDR word-address width; must exceed ADDRESS_WIDTH
- DATA_WIDTH, 8, word width
- LINE_WORDS_LOG2, 2, log2 words per line; INDEX_WIDTH = ADDRESS_WIDTH − LINE_WORDS_LOG2; TAG_WIDTH = MEM_ADDRESS_WIDTH − ADDRESS_WIDTH

Ports (clock and reset are the already-decided pair):
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- ProcRead  in  1  processor read request, held until accepted (ProcStall low)
- ProcAddress  in  MEM_ADDRESS_WIDTH  processor word address; low ADDRESS_WIDTH bits feed the mux ProcessorAddress input
- ProcStall  out  1  processor must hold request
- Flush  in  1  single-cycle pulse: invalidate all lines
- FlushBusy  out  1  flush sequence in progress
- Select  out  1  address mux select: 1 = FSMAddress, 0 = processor address
- FSMAddress  out  ADDRESS_WIDTH  cache fill write address
- CacheWrite  out  1  cache RAM write enable
- CacheWriteData  out  DATA_WIDTH  registered copy of MemReadData
- MemReadReq  out  1  line-read request, held until MemReadAck
- MemAddress  out  MEM_ADDRESS_WIDTH  line base address (low LINE_WORDS_LOG2 bits zero)
- MemReadAck  in  1  DDR accepted request
- MemReadData  in  DATA_WIDTH  returned word
- MemDataValid  in  1  MemReadData valid this cycle; beats may have gaps

## Operation
- Address split: tag = ProcAddress[MSB:ADDRESS_WIDTH], index = ProcAddress[ADDRESS_WIDTH−1:LINE_WORDS_LOG2], word = low LINE_WORDS_LOG2 bits.
- Internal storage: tag array of 2^INDEX_WIDTH × TAG_WIDTH and a valid vector of 2^INDEX_WIDTH bits.
- hit = ProcRead & valid[index] & (tag array[index] == tag), evaluated combinationally in IDLE only.
- States and transitions:
  - IDLE
    - Flush or pending flush → FLUSH (priority over a miss).
    - ProcRead & !hit → REQ; latch tag and index.
  - REQ
    - MemReadReq=1.
    - MemReadAck → DATA; word counter cleared.
  - DATA
    - Each MemDataValid: register the word, then next cycle assert CacheWrite with FSMAddress = {index, counter}, and increment the counter.
    - After LINE_WORDS writes → UPDATE.
  - UPDATE: write tag, set valid[index], → IDLE.
  - FLUSH
    - Clears one valid bit per cycle; index counter runs 0..2^INDEX_WIDTH−1.
    - After the last index → IDLE.
- Select = 1 in REQ, DATA, UPDATE; 0 otherwise.
- ProcStall = (state ≠ IDLE) | (ProcRead & !hit) | Flush.
- Flush arriving in REQ/DATA/UPDATE: latched as pending; the fill completes first, then FLUSH runs. Its valid-set is wiped.
- A second Flush during FLUSH is absorbed; no restart.
- MemDataValid outside DATA is ignored.
- Counters wrap naturally at their width; no overflow beyond the terminal compare.

## Timing
- Reset values: state IDLE, valid vector all 0, ProcStall 0, FlushBusy 0, Select 0, FSMAddress 0, CacheWrite 0, CacheWriteData 0, MemReadReq 0, MemAddress 0, pending-flush 0.
- Reset mid-fill: everything returns to the reset values next cycle and all lines are invalid. The partial line is discarded; a late MemDataValid is ignored.
- Hit: zero stall cycles; the cache RAM read latency is outside this block.
- Miss: MemReadReq rises the cycle after the miss is detected.
- Last CacheWrite occurs one cycle after the last MemDataValid; UPDATE follows; the retry hits in the next IDLE cycle.
- Minimum miss penalty is LINE_WORDS + 4 cycles (ack same cycle as req, gapless data).
- FLUSH takes 2^INDEX_WIDTH cycles. FlushBusy is high exactly while in FLUSH or pending.

## Structure
- Shared package/header holds:
  - state encoding constants (IDLE, REQ, DATA, UPDATE, FLUSH)
  - derived width localparams INDEX_WIDTH and TAG_WIDTH, reused by the cache datapath
- One natural sub-module: cache_tag_store (tag array plus valid vector, with lookup compare, write port, and per-index clear).
- The existing cache address mux is instantiated by the parent, not inside this block.

## Test plan
Defaults apply: LINE_WORDS = 4.
- Cold miss:
  - After reset, read 0x1234 → ProcStall=1.
  - MemReadReq with MemAddress 0x1234 & ~3 = 0x1234.
  - After ack, four beats 0xA0..0xA3 → CacheWrite at FSMAddress 0x234..0x237 with those data; Select=1 throughout.
  - Stall drops and the retry hits.
- Hit: read 0x1235 after the fill → ProcStall stays 0, no MemReadReq.
- Conflict: read 0x5234 (same index, different tag) → miss. Refill overwrites the tag; a subsequent 0x1234 misses again.
- Gapped data, delayed ack:
  - Ack after 5 cycles; beats separated by 0–3 idle cycles → exactly 4 CacheWrites in order.
  - MemReadReq stays high until ack.
- Flush during fill:
  - Pulse Flush in DATA → fill completes, then FlushBusy stays high for 256 cycles.
  - Afterwards 0x1234 misses.
- Reset mid-DATA: assert rst_n=0 after 2 beats → all outputs return to reset values; 0x1234 misses afterwards.
